io_bus: RTL and testbench

Memory-side bus target for the eightbit core: it consumes the core's single memory port (`addr`, `data_out`, `we`) and returns read data on the core's `data_in`. It decodes an 8-bit address space into 240 bytes of program/data RAM and a bank of memory-mapped I/O registers. The I/O bank holds GPIO, a free-running timer and an 8N1 UART transmitter. It is the only block downstream of the core's memory interface.

---
 rtl/io_bus_pkg.sv | 23 ++
 rtl/io_bus_uart_tx.sv | 73 +++++++
 rtl/io_bus.sv | 114 +++++++++++
 tb/tb_io_bus.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// Shared constants and types for the io_bus memory-side target:
// address map, UART status bit positions and the UART transmitter states.
`timescale 1ns/1ps
package io_bus_pkg;

    localparam logic [7:0] ADDR_RAM_TOP     = 8'hEF;
    localparam logic [7:0] ADDR_GPIO_OUT    = 8'hF0;
    localparam logic [7:0] ADDR_GPIO_IN     = 8'hF1;
    localparam logic [7:0] ADDR_UART_DATA   = 8'hF2;
    localparam logic [7:0] ADDR_UART_STATUS = 8'hF3;
    localparam logic [7:0] ADDR_TIMER       = 8'hF4;

    localparam int ST_BUSY    = 0;
    localparam int ST_OVERRUN = 1;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

endpackage

// File: rtl/io_bus_uart_tx.sv
// 8N1 serial transmitter: start bit, eight data bits LSB first, stop bit,
// each held for CLKS_PER_BIT cycles. A new byte is only taken from IDLE.
`timescale 1ns/1ps
module uart_tx
    import io_bus_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    uart_state_t state;
    uart_state_t state_next;
    logic [7:0]  clk_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        bit_done;

    assign bit_done = (clk_cnt == 8'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= UART_IDLE;
            clk_cnt <= 8'd0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
        end else begin
            state <= state_next;
            if (state == UART_IDLE) begin
                clk_cnt <= 8'd0;
                bit_idx <= 3'd0;
                if (start) begin
                    shift <= data;
                end
            end else if (bit_done) begin
                clk_cnt <= 8'd0;
                if (state == UART_DATA) begin
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                clk_cnt <= clk_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            UART_IDLE:  if (start) state_next = UART_START;
            UART_START: if (bit_done) state_next = UART_DATA;
            UART_DATA:  if (bit_done && bit_idx == 3'd7) state_next = UART_STOP;
            UART_STOP:  if (bit_done) state_next = UART_IDLE;
            default:    state_next = UART_IDLE;
        endcase
    end

    // The line level is decoded from state so reset forces it high at once.
    always_comb begin
        tx   = 1'b1;
        busy = (state != UART_IDLE);
        case (state)
            UART_START: tx = 1'b0;
            UART_DATA:  tx = shift[bit_idx];
            default:    tx = 1'b1;
        endcase
    end

endmodule

// File: rtl/io_bus.sv
// Memory-side bus target for the eightbit core: 240 bytes of RAM plus
// memory-mapped GPIO, a free-running timer and a UART transmitter.
`timescale 1ns/1ps
module io_bus
    import io_bus_pkg::*;
#(
    parameter int    CLKS_PER_BIT = 16,
    parameter string INIT_FILE    = ""
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] addr,
    input  logic [7:0] wr_data,
    input  logic       we,
    output logic [7:0] rd_data,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out,
    output logic       uart_tx
);

    logic [7:0] ram [0:239];
    logic [7:0] sync1;
    logic [7:0] sync2;
    logic [7:0] uart_data;
    logic       overrun;
    logic [7:0] timer;
    logic       uart_busy;
    logic       ram_sel;
    logic       uart_wr;
    logic       uart_start;
    logic       overrun_set;
    logic       overrun_clr;
    logic [7:0] status;
    logic [7:0] rd_next;

    assign ram_sel     = (addr <= ADDR_RAM_TOP);
    assign uart_wr     = we && (addr == ADDR_UART_DATA);
    assign uart_start  = uart_wr && !uart_busy;
    assign overrun_set = uart_wr && uart_busy;
    assign overrun_clr = we && (addr == ADDR_UART_STATUS) && wr_data[ST_OVERRUN];

    always_comb begin
        status              = 8'h00;
        status[ST_BUSY]     = uart_busy;
        status[ST_OVERRUN]  = overrun;
    end

    always_comb begin
        rd_next = 8'h00;
        if (ram_sel) begin
            rd_next = ram[addr];
        end else begin
            case (addr)
                ADDR_GPIO_OUT:    rd_next = gpio_out;
                ADDR_GPIO_IN:     rd_next = sync2;
                ADDR_UART_DATA:   rd_next = uart_data;
                ADDR_UART_STATUS: rd_next = status;
                ADDR_TIMER:       rd_next = timer;
                default:          rd_next = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (we && ram_sel) begin
            ram[addr] <= wr_data;
        end
    end

    // Sampling rd_next at the edge makes read-during-write return the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data   <= 8'h00;
            gpio_out  <= 8'h00;
            sync1     <= 8'h00;
            sync2     <= 8'h00;
            uart_data <= 8'h00;
            overrun   <= 1'b0;
            timer     <= 8'h00;
        end else begin
            rd_data <= rd_next;
            sync1   <= gpio_in;
            sync2   <= sync1;
            if (we && addr == ADDR_GPIO_OUT) begin
                gpio_out <= wr_data;
            end
            if (uart_start) begin
                uart_data <= wr_data;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
            if (we && addr == ADDR_TIMER) begin
                timer <= wr_data;
            end else begin
                timer <= timer + 8'd1;
            end
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk  (clk),
        .rst  (rst),
        .start(uart_start),
        .data (wr_data),
        .tx   (uart_tx),
        .busy (uart_busy)
    );

endmodule

// File: tb/tb_io_bus.sv
// Self-checking bench for io_bus: directed steps followed by random traffic,
// every cycle compared against a frame-timing reference model.
`timescale 1ns/1ps
module tb_io_bus;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] addr;
    logic [7:0] wr_data;
    logic       we;
    logic [7:0] rd_data;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;
    logic       uart_tx;

    io_bus #(
        .CLKS_PER_BIT(CPB),
        .INIT_FILE("")
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .wr_data (wr_data),
        .we      (we),
        .rd_data (rd_data),
        .gpio_in (gpio_in),
        .gpio_out(gpio_out),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram_m [240];
    bit         ram_known [240];
    logic [7:0] gpio_out_m;
    logic [7:0] s1_m;
    logic [7:0] s2_m;
    logic [7:0] uart_data_m;
    logic [7:0] timer_m;
    bit         overrun_m;
    bit         frame_active;
    int         frame_start;
    logic [7:0] frame_byte;
    int         edge_cnt;

    // A frame accepted at edge N occupies edges N .. N+10*CPB-1 afterwards.
    function automatic bit busy_after(int e);
        return frame_active && ((e - frame_start) < 10 * CPB);
    endfunction

    function automatic logic tx_after(int e);
        int k;
        int idx;
        k = e - frame_start;
        if (!frame_active || k >= 10 * CPB) return 1'b1;
        idx = k / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return frame_byte[idx - 1];
    endfunction

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        gpio_out_m   = 8'h00;
        s1_m         = 8'h00;
        s2_m         = 8'h00;
        uart_data_m  = 8'h00;
        timer_m      = 8'h00;
        overrun_m    = 1'b0;
        frame_active = 1'b0;
        frame_start  = 0;
        frame_byte   = 8'h00;
    endtask

    task automatic apply_stimulus(input logic [7:0] a, input bit w, input logic [7:0] d,
                                  input logic [7:0] g);
        bit         busy_pre;
        bit         rd_known;
        logic [7:0] exp_rd;
        @(negedge clk);
        addr     = a;
        we       = w;
        wr_data  = d;
        gpio_in  = g;
        busy_pre = busy_after(edge_cnt);
        rd_known = 1'b1;
        exp_rd   = 8'h00;
        if (a <= 8'hEF) begin
            rd_known = ram_known[a];
            exp_rd   = ram_m[a];
        end else begin
            case (a)
                8'hF0:   exp_rd = gpio_out_m;
                8'hF1:   exp_rd = s2_m;
                8'hF2:   exp_rd = uart_data_m;
                8'hF3:   exp_rd = {6'b0, overrun_m, busy_pre};
                8'hF4:   exp_rd = timer_m;
                default: exp_rd = 8'h00;
            endcase
        end
        @(posedge clk);
        edge_cnt++;
        s2_m    = s1_m;
        s1_m    = g;
        timer_m = (w && a == 8'hF4) ? d : timer_m + 8'd1;
        if (w) begin
            if (a <= 8'hEF) begin
                ram_m[a]     = d;
                ram_known[a] = 1'b1;
            end else if (a == 8'hF0) begin
                gpio_out_m = d;
            end else if (a == 8'hF2) begin
                if (busy_pre) begin
                    overrun_m = 1'b1;
                end else begin
                    uart_data_m  = d;
                    frame_byte   = d;
                    frame_start  = edge_cnt;
                    frame_active = 1'b1;
                end
            end else if (a == 8'hF3 && d[1]) begin
                overrun_m = 1'b0;
            end
        end
        #1;
        if (rd_known) check_output($sformatf("rd_data@%0d addr=%h", edge_cnt, a), rd_data, exp_rd);
        check_output($sformatf("gpio_out@%0d", edge_cnt), gpio_out, gpio_out_m);
        check_output($sformatf("uart_tx@%0d", edge_cnt), {7'b0, uart_tx}, {7'b0, tx_after(edge_cnt)});
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_output("reset_rd_data", rd_data, 8'h00);
        check_output("reset_gpio_out", gpio_out, 8'h00);
        check_output("reset_uart_tx", {7'b0, uart_tx}, 8'h01);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] g;
        rst      = 1'b1;
        addr     = 8'h00;
        wr_data  = 8'h00;
        we       = 1'b0;
        gpio_in  = 8'h00;
        edge_cnt = 0;
        for (int i = 0; i < 240; i++) ram_known[i] = 1'b0;
        model_reset();
        #1;
        check_output("por_rd_data", rd_data, 8'h00);
        check_output("por_gpio_out", gpio_out, 8'h00);
        check_output("por_uart_tx", {7'b0, uart_tx}, 8'h01);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // RAM write/read and unmapped read
        apply_stimulus(8'h10, 1'b1, 8'hA5, 8'h00);
        apply_stimulus(8'h10, 1'b0, 8'h00, 8'h00);
        apply_stimulus(8'hF8, 1'b0, 8'h00, 8'h00);
        apply_stimulus(8'hF8, 1'b1, 8'h77, 8'h00);
        apply_stimulus(8'hF8, 1'b0, 8'h00, 8'h00);

        // Read-during-write on RAM
        apply_stimulus(8'h20, 1'b1, 8'h11, 8'h00);
        apply_stimulus(8'h20, 1'b1, 8'h22, 8'h00);
        apply_stimulus(8'h20, 1'b0, 8'h00, 8'h00);

        // GPIO out and synchronised GPIO in
        apply_stimulus(8'hF0, 1'b1, 8'h3C, 8'h00);
        apply_stimulus(8'hF0, 1'b0, 8'h00, 8'h81);
        apply_stimulus(8'hF1, 1'b0, 8'h00, 8'h81);
        apply_stimulus(8'hF1, 1'b0, 8'h00, 8'h81);
        apply_stimulus(8'hF1, 1'b0, 8'h00, 8'h81);

        // Full UART frame of 0x55, polling status past the end of frame
        apply_stimulus(8'hF2, 1'b1, 8'h55, 8'h81);
        for (int i = 0; i < 10 * CPB + 3; i++) apply_stimulus(8'hF3, 1'b0, 8'h00, 8'h81);
        apply_stimulus(8'hF2, 1'b0, 8'h00, 8'h81);

        // Overrun: second write 3 cycles later is dropped, then clear it
        apply_stimulus(8'hF2, 1'b1, 8'hC3, 8'h81);
        apply_stimulus(8'hF3, 1'b0, 8'h00, 8'h81);
        apply_stimulus(8'hF3, 1'b0, 8'h00, 8'h81);
        apply_stimulus(8'hF2, 1'b1, 8'h3E, 8'h81);
        for (int i = 0; i < 10 * CPB; i++) apply_stimulus(8'hF3, 1'b0, 8'h00, 8'h81);
        apply_stimulus(8'hF2, 1'b0, 8'h00, 8'h81);
        apply_stimulus(8'hF3, 1'b1, 8'h02, 8'h81);
        apply_stimulus(8'hF3, 1'b0, 8'h00, 8'h81);

        // Write exactly at the end-of-frame edge is still dropped
        apply_stimulus(8'hF2, 1'b1, 8'h96, 8'h81);
        for (int i = 0; i < 10 * CPB - 1; i++) apply_stimulus(8'h00, 1'b0, 8'h00, 8'h81);
        apply_stimulus(8'hF2, 1'b1, 8'h69, 8'h81);
        apply_stimulus(8'hF3, 1'b0, 8'h00, 8'h81);
        apply_stimulus(8'hF3, 1'b1, 8'hFD, 8'h81);
        apply_stimulus(8'hF3, 1'b1, 8'h02, 8'h81);
        apply_stimulus(8'hF3, 1'b0, 8'h00, 8'h81);

        // Timer load and wrap
        apply_stimulus(8'hF4, 1'b1, 8'hFE, 8'h81);
        for (int i = 0; i < 4; i++) apply_stimulus(8'hF4, 1'b0, 8'h00, 8'h81);

        // Reset in the middle of a frame
        apply_stimulus(8'hF2, 1'b1, 8'hA3, 8'h81);
        for (int i = 0; i < 9; i++) apply_stimulus(8'hF4, 1'b0, 8'h00, 8'h81);
        do_reset();
        apply_stimulus(8'hF3, 1'b0, 8'h00, 8'h00);
        apply_stimulus(8'hF4, 1'b0, 8'h00, 8'h00);
        apply_stimulus(8'hF2, 1'b0, 8'h00, 8'h00);
        apply_stimulus(8'h10, 1'b0, 8'h00, 8'h00);

        // Random traffic over RAM and the I/O bank
        g = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 0) a = 8'($urandom_range(0, 63));
            else a = 8'($urandom_range(240, 255));
            if ((i % 8) == 0) g = 8'($urandom);
            apply_stimulus(a, ($urandom_range(0, 3) == 0), 8'($urandom), g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
